trap_ctrl: RTL and testbench

Trap sequencer for the machine-mode CSR file. Arbitrates synchronous exceptions, enabled machine interrupts and `mret` into one trap or return event, and drains the pipeline through a flush handshake. Issues the single-cycle trap-entry or `mret` commit strobe to the CSR file, then redirects fetch to the handler or to `mepc`. Sits between the execute/commit stage, the CSR file and the fetch unit.

---
 rtl/trap_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exception / interrupt / mret, drains the pipe, commits, redirects.
// Optional macro COTM32_VECTORED_MTVEC_EN enables vectored interrupt redirect when mtvec[1:0]==2'b01.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting; the only state in which events are sampled
// S_DRAIN    | flush requested, waiting for pipeline-drained ack
// S_COMMIT   | one-cycle trap-entry or mret strobe to the CSR file
// S_REDIRECT | one-cycle fetch redirect strobe, then back to idle
module trap_ctrl #(
  parameter int MXLEN = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [5:0]       i_exc,
  input  logic [MXLEN-1:0] i_exc_tval,
  input  logic [MXLEN-1:0] i_pc,
  input  logic             i_mret,
  input  logic             i_mstatus_mie,
  input  logic [MXLEN-1:0] i_mie,
  input  logic [MXLEN-1:0] i_mip,
  input  logic [MXLEN-1:0] i_mtvec,
  input  logic [MXLEN-1:0] i_mepc,
  output logic             o_flush_req,
  input  logic             i_flush_ack,
  output logic             o_trap_req,
  output logic             o_trap_mret,
  output logic [MXLEN-1:0] o_trap_cause,
  output logic [MXLEN-1:0] o_trap_tval,
  output logic [MXLEN-1:0] o_trap_pc,
  output logic             o_redirect_valid,
  output logic [MXLEN-1:0] o_redirect_pc,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_COMMIT   = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t     state;
  logic       lat_mret;
  logic       lat_irq;
  logic [3:0] lat_code;

  logic       exc_hit;
  logic [3:0] exc_code;
  logic [2:0] irq_pend;
  logic       irq_hit;
  logic [3:0] irq_code;

  logic [MXLEN-1:0] trap_base;
  logic [MXLEN-1:0] trap_target;

  // Exception and interrupt arbitration; irq_pend is {MEI, MSI, MTI}.
  always_comb begin
    exc_hit  = |i_exc;
    exc_code = 4'd0;
    if (i_exc[0])      exc_code = 4'd0;
    else if (i_exc[1]) exc_code = 4'd2;
    else if (i_exc[2]) exc_code = 4'd3;
    else if (i_exc[3]) exc_code = 4'd11;
    else if (i_exc[4]) exc_code = 4'd4;
    else if (i_exc[5]) exc_code = 4'd6;

    irq_pend[2] = i_mstatus_mie & i_mie[11] & i_mip[11];
    irq_pend[1] = i_mstatus_mie & i_mie[3]  & i_mip[3];
    irq_pend[0] = i_mstatus_mie & i_mie[7]  & i_mip[7];
    irq_hit     = |irq_pend;
    irq_code    = 4'd0;
    if (irq_pend[2])      irq_code = 4'd11;
    else if (irq_pend[1]) irq_code = 4'd3;
    else if (irq_pend[0]) irq_code = 4'd7;
  end

  always_comb begin
    trap_base   = {i_mtvec[MXLEN-1:2], 2'b00};
    trap_target = trap_base;
`ifdef COTM32_VECTORED_MTVEC_EN
    if (lat_irq && (i_mtvec[1:0] == 2'b01))
      trap_target = trap_base + {{(MXLEN-6){1'b0}}, lat_code, 2'b00};
`endif
  end

  // Only bits 3/7/11 of mie/mip matter; mtvec mode and the latched code are build-dependent.
  logic unused_bits;
  assign unused_bits = ^{i_mie, i_mip, i_mtvec[1:0], lat_code};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= S_IDLE;
      lat_mret         <= 1'b0;
      lat_irq          <= 1'b0;
      lat_code         <= 4'd0;
      o_flush_req      <= 1'b0;
      o_trap_req       <= 1'b0;
      o_trap_mret      <= 1'b0;
      o_trap_cause     <= '0;
      o_trap_tval      <= '0;
      o_trap_pc        <= '0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
      o_busy           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          o_redirect_valid <= 1'b0;
          if (exc_hit) begin
            lat_mret     <= 1'b0;
            lat_irq      <= 1'b0;
            lat_code     <= exc_code;
            o_trap_cause <= {{(MXLEN-4){1'b0}}, exc_code};
            o_trap_tval  <= i_exc_tval;
            o_trap_pc    <= i_pc;
            o_flush_req  <= 1'b1;
            o_busy       <= 1'b1;
            state        <= S_DRAIN;
          end else if (irq_hit) begin
            // Also covers an interrupt coinciding with mret: the mret PC is saved so it re-executes.
            lat_mret     <= 1'b0;
            lat_irq      <= 1'b1;
            lat_code     <= irq_code;
            o_trap_cause <= {1'b1, {(MXLEN-5){1'b0}}, irq_code};
            o_trap_tval  <= '0;
            o_trap_pc    <= i_pc;
            o_flush_req  <= 1'b1;
            o_busy       <= 1'b1;
            state        <= S_DRAIN;
          end else if (i_mret) begin
            lat_mret     <= 1'b1;
            lat_irq      <= 1'b0;
            lat_code     <= 4'd0;
            o_trap_cause <= '0;
            o_trap_tval  <= '0;
            o_trap_pc    <= i_pc;
            o_flush_req  <= 1'b1;
            o_busy       <= 1'b1;
            state        <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (i_flush_ack) begin
            o_flush_req <= 1'b0;
            o_trap_req  <= ~lat_mret;
            o_trap_mret <= lat_mret;
            state       <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          o_trap_req       <= 1'b0;
          o_trap_mret      <= 1'b0;
          o_redirect_valid <= 1'b1;
          o_redirect_pc    <= lat_mret ? i_mepc : trap_target;
          state            <= S_REDIRECT;
        end
        S_REDIRECT: begin
          o_redirect_valid <= 1'b0;
          o_busy           <= 1'b0;
          state            <= S_IDLE;
        end
        default: begin
          o_flush_req      <= 1'b0;
          o_trap_req       <= 1'b0;
          o_trap_mret      <= 1'b0;
          o_redirect_valid <= 1'b0;
          o_busy           <= 1'b0;
          state            <= S_IDLE;
        end
      endcase
    end
  end

  a_strobe_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(o_trap_req && o_trap_mret));
  a_busy_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_busy == (state != S_IDLE));

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl; expected redirect for vectored interrupts follows COTM32_VECTORED_MTVEC_EN.
module tb_trap_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [5:0]  i_exc;
  logic [31:0] i_exc_tval;
  logic [31:0] i_pc;
  logic        i_mret;
  logic        i_mstatus_mie;
  logic [31:0] i_mie;
  logic [31:0] i_mip;
  logic [31:0] i_mtvec;
  logic [31:0] i_mepc;
  logic        o_flush_req;
  logic        i_flush_ack;
  logic        o_trap_req;
  logic        o_trap_mret;
  logic [31:0] o_trap_cause;
  logic [31:0] o_trap_tval;
  logic [31:0] o_trap_pc;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  trap_ctrl #(.MXLEN(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_exc(i_exc), .i_exc_tval(i_exc_tval),
    .i_pc(i_pc), .i_mret(i_mret), .i_mstatus_mie(i_mstatus_mie), .i_mie(i_mie),
    .i_mip(i_mip), .i_mtvec(i_mtvec), .i_mepc(i_mepc), .o_flush_req(o_flush_req),
    .i_flush_ack(i_flush_ack), .o_trap_req(o_trap_req), .o_trap_mret(o_trap_mret),
    .o_trap_cause(o_trap_cause), .o_trap_tval(o_trap_tval), .o_trap_pc(o_trap_pc),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Event inputs must be applied before the call; the next edge is the sampling edge.
  task automatic run_seq(input int ack_dly, input bit exp_mret, input logic [31:0] exp_cause,
                         input logic [31:0] exp_tval, input logic [31:0] exp_pc,
                         input logic [31:0] exp_tgt);
    tick();
    i_exc  = '0;
    i_mret = 1'b0;
    chk("busy_enter", 32'(o_busy), 32'd1);
    chk("pc_latched", o_trap_pc, exp_pc);
    if (!exp_mret) begin
      chk("cause_latched", o_trap_cause, exp_cause);
      chk("tval_latched", o_trap_tval, exp_tval);
    end
    for (int i = 0; i < ack_dly; i++) begin
      chk("flush_wait", 32'(o_flush_req), 32'd1);
      chk("no_early_strobe", 32'(o_trap_req | o_trap_mret), 32'd0);
      tick();
    end
    i_flush_ack = 1'b1;
    chk("flush_ack_cycle", 32'(o_flush_req), 32'd1);
    tick();
    i_flush_ack = 1'b0;
    chk("flush_drop", 32'(o_flush_req), 32'd0);
    chk("trap_req", 32'(o_trap_req), 32'(!exp_mret));
    chk("trap_mret", 32'(o_trap_mret), 32'(exp_mret));
    chk("redir_early", 32'(o_redirect_valid), 32'd0);
    tick();
    chk("redir_valid", 32'(o_redirect_valid), 32'd1);
    chk("redir_pc", o_redirect_pc, exp_tgt);
    chk("strobe_width", 32'(o_trap_req | o_trap_mret), 32'd0);
    chk("busy_redirect", 32'(o_busy), 32'd1);
    tick();
    chk("redir_drop", 32'(o_redirect_valid), 32'd0);
    chk("busy_exit", 32'(o_busy), 32'd0);
    if (!exp_mret) chk("cause_hold", o_trap_cause, exp_cause);
  endtask

  logic [31:0] exp_vec_tgt;

  initial begin
    i_rst_n = 1'b0; i_exc = '0; i_exc_tval = '0; i_pc = '0; i_mret = 1'b0;
    i_mstatus_mie = 1'b0; i_mie = '0; i_mip = '0; i_mtvec = '0; i_mepc = '0;
    i_flush_ack = 1'b0;
    #12;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_flush", 32'(o_flush_req), 32'd0);
    chk("rst_strobes", 32'({o_trap_req, o_trap_mret, o_redirect_valid}), 32'd0);
    chk("rst_cause", o_trap_cause, 32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Illegal instruction, immediate ack.
    i_exc = 6'b000010; i_exc_tval = 32'hDEADBEEF; i_pc = 32'h100; i_mtvec = 32'h8000;
    run_seq(0, 1'b0, 32'd2, 32'hDEADBEEF, 32'h100, 32'h8000);

    // Multiple exceptions: ebreak beats load/store misaligned; then load beats store.
    i_exc = 6'b110100; i_exc_tval = 32'h11; i_pc = 32'h120;
    run_seq(1, 1'b0, 32'd3, 32'h11, 32'h120, 32'h8000);
    i_exc = 6'b110000; i_exc_tval = 32'h22; i_pc = 32'h124;
    run_seq(0, 1'b0, 32'd4, 32'h22, 32'h124, 32'h8000);

    // MEI and MTI pending, mtvec in vectored mode.
    i_mstatus_mie = 1'b1; i_mie = 32'h0000_0880; i_mip = 32'h0000_0880;
    i_mtvec = 32'h8001; i_pc = 32'h300; i_exc_tval = 32'h55;
`ifdef COTM32_VECTORED_MTVEC_EN
    exp_vec_tgt = 32'h802C;
`else
    exp_vec_tgt = 32'h8000;
`endif
    run_seq(0, 1'b0, 32'h8000000B, 32'h0, 32'h300, exp_vec_tgt);
    i_mip = '0; i_mie = '0; i_mstatus_mie = 1'b0; i_mtvec = 32'h8000;

    // mret with ack delayed 5 cycles: flush high for 6 cycles.
    i_mret = 1'b1; i_mepc = 32'h240; i_pc = 32'h500;
    run_seq(5, 1'b1, 32'h0, 32'h0, 32'h500, 32'h240);

    // Interrupt coinciding with mret wins and keeps the mret PC.
    i_mret = 1'b1; i_mstatus_mie = 1'b1; i_mie = 32'h8; i_mip = 32'h8; i_pc = 32'h600;
    run_seq(2, 1'b0, 32'h80000003, 32'h0, 32'h600, 32'h8000);
    i_mip = '0; i_mie = '0;

    // ecall beats pending MTI; MTI follows right after the return.
    i_mie = 32'h80; i_mip = 32'h80; i_exc = 6'b001000; i_exc_tval = 32'h77; i_pc = 32'h400;
    run_seq(0, 1'b0, 32'd11, 32'h77, 32'h400, 32'h8000);
    i_pc = 32'h404;
    run_seq(0, 1'b0, 32'h80000007, 32'h0, 32'h404, 32'h8000);
    i_mip = '0; i_mie = '0;

    // MTI pending but globally disabled.
    i_mstatus_mie = 1'b0; i_mie = 32'h80; i_mip = 32'h80;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("masked_busy", 32'(o_busy), 32'd0);
      chk("masked_flush", 32'(o_flush_req), 32'd0);
    end
    i_mip = '0; i_mie = '0;

    // Reset while draining aborts the event.
    i_exc = 6'b000001; i_pc = 32'h700; i_exc_tval = 32'h99;
    tick();
    i_exc = '0;
    chk("pre_rst_flush", 32'(o_flush_req), 32'd1);
    chk("pre_rst_pc", o_trap_pc, 32'h700);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_flush", 32'(o_flush_req), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_pc", o_trap_pc, 32'h0);
    chk("mid_rst_tval", o_trap_tval, 32'h0);
    tick();
    i_rst_n = 1'b1;
    i_flush_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_strobe", 32'({o_trap_req, o_trap_mret, o_redirect_valid}), 32'd0);
      chk("post_rst_busy", 32'(o_busy), 32'd0);
    end
    i_flush_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
